sync_ram_dp: RTL

Parametrised simple-dual-port synchronous RAM. It replaces the combinational single-port 8x1024 memory for all new datapaths.
- One write port and one read port, with per-byte write enables.
- Read latency of 1 or 2 cycles, with a read-data valid flag.
- Selectable read-during-write behaviour.
- A hardware clear sequencer zeroes the whole array after reset.
- It sits between the packet/control logic and storage. It is the standard buffer primitive for FIFOs and lookup tables.

---
 rtl/sync_ram_pkg.sv | 30 +++
 rtl/sync_ram_clr_seq.sv | 53 +++++
 rtl/sync_ram_dp.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg: shared constants, sequencer state type and byte-parity helper
// for the sync_ram_dp buffer primitive.
package sync_ram_pkg;

  // Read-during-write selections for the RDW_MODE parameter.
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest data word the parity helper can handle; callers zero-extend.
  localparam int MAX_DATA_W = 512;
  localparam int MAX_BYTES  = MAX_DATA_W / 8;

  // Clear sequencer states: zero the array after reset, then serve users.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } seq_state_t;

  // Even parity per byte: the stored bit equals the XOR of the byte, so the
  // nine bits together always hold an even number of ones.
  function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DATA_W-1:0] data);
    logic [MAX_BYTES-1:0] par;
    par = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/sync_ram_clr_seq.sv
// sync_ram_clr_seq: after reset, walks every address once and requests an
// all-zero write, holding init_busy high until the last word is written.
module sync_ram_clr_seq
  import sync_ram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;

  // Sequencer FSM: one zero write per cycle in CLEAR, leave on the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        READY: begin
          state     <= READY;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= CLEAR;
          clr_cnt   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign clr_addr = clr_cnt;
  assign clr_we   = init_busy;

endmodule

// File: rtl/sync_ram_dp.sv
// sync_ram_dp: simple dual-port synchronous RAM with per-byte write enables,
// 1- or 2-cycle read latency, selectable read-during-write behaviour and a
// hardware clear after reset. Define SYNC_RAM_PARITY_EN to store an even
// parity bit per byte and flag mismatches on rd_err.
module sync_ram_dp
  import sync_ram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1 << ADDR_W,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_READ_FIRST
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_err
);

  localparam int              NB        = DATA_W / 8;
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Reject configurations the datapath cannot honour.
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sync_ram_dp: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("sync_ram_dp: RDW_MODE must be 0 or 1");
  end
  if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_width
    $error("sync_ram_dp: DATA_W must be a non-zero multiple of 8 within MAX_DATA_W");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("sync_ram_dp: DEPTH must be between 1 and 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem_data [DEPTH];
`ifdef SYNC_RAM_PARITY_EN
  logic [NB-1:0]     mem_par  [DEPTH];
`endif

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              unused_clr_addr;

  sync_ram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  // Only the low index bits address the array; the sequencer never exceeds DEPTH-1.
  assign unused_clr_addr = ^clr_addr;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              w_act;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_data;
  logic [NB-1:0]     w_be;
  logic              rd_act;
  logic [IDX_W-1:0]  r_idx;
  logic              rdw_hit;
  logic [DATA_W-1:0] rd_word;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_EXT;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_EXT;
  assign r_idx       = rd_addr[IDX_W-1:0];

  // Write port mux: the clear sequencer owns the array until it finishes.
  always_comb begin
    w_act  = 1'b0;
    w_idx  = '0;
    w_data = '0;
    w_be   = '0;
    if (init_busy) begin
      w_act = clr_we;
      w_idx = clr_addr[IDX_W-1:0];
      w_be  = '1;
    end else begin
      w_act  = wr_en && wr_in_range;
      w_idx  = wr_addr[IDX_W-1:0];
      w_data = wr_data;
      w_be   = wr_be;
    end
  end

  assign rd_act  = rd_en && !init_busy;
  assign rdw_hit = (RDW_MODE == RDW_WRITE_FIRST) && w_act && !init_busy &&
                   (wr_addr == rd_addr);

`ifdef SYNC_RAM_PARITY_EN
  logic [NB-1:0] w_par;
  logic [NB-1:0] rd_par_stored;
  logic          rd_perr;

  assign w_par = NB'(byte_parity(MAX_DATA_W'(w_data)));
`endif

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (w_act) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) begin
          mem_data[w_idx][8*i +: 8] <= w_data[8*i +: 8];
`ifdef SYNC_RAM_PARITY_EN
          mem_par[w_idx][i] <= w_par[i];
`endif
        end
      end
    end
  end

  // Read word: out-of-range reads return zero, write-first merges enabled lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_data[r_idx];
      if (rdw_hit) begin
        for (int i = 0; i < NB; i++) begin
          if (w_be[i]) begin
            rd_word[8*i +: 8] = w_data[8*i +: 8];
          end
        end
      end
    end
  end

`ifdef SYNC_RAM_PARITY_EN
  // Stored parity for the word being read, following the same lane merge.
  always_comb begin
    rd_par_stored = '0;
    if (rd_in_range) begin
      rd_par_stored = mem_par[r_idx];
      if (rdw_hit) begin
        for (int i = 0; i < NB; i++) begin
          if (w_be[i]) begin
            rd_par_stored[i] = w_par[i];
          end
        end
      end
    end
  end

  assign rd_perr = |(rd_par_stored ^ NB'(byte_parity(MAX_DATA_W'(rd_word))));
`endif

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
`ifdef SYNC_RAM_PARITY_EN
  logic              s1_err;
`endif

  // First read stage: capture the word on a request, otherwise hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
`ifdef SYNC_RAM_PARITY_EN
      s1_err   <= 1'b0;
`endif
    end else begin
      s1_valid <= rd_act;
      if (rd_act) begin
        s1_data <= rd_word;
`ifdef SYNC_RAM_PARITY_EN
        s1_err  <= rd_perr;
`endif
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic              s2_valid;
      logic [DATA_W-1:0] s2_data;
`ifdef SYNC_RAM_PARITY_EN
      logic              s2_err;
`endif

      // Second read stage: one more register so data lands two cycles out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
`ifdef SYNC_RAM_PARITY_EN
          s2_err   <= 1'b0;
`endif
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
`ifdef SYNC_RAM_PARITY_EN
            s2_err  <= s1_err;
`endif
          end
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
`ifdef SYNC_RAM_PARITY_EN
      assign rd_err   = s2_err;
`endif
    end else begin : g_lat1
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
`ifdef SYNC_RAM_PARITY_EN
      assign rd_err   = s1_err;
`endif
    end
  endgenerate

`ifndef SYNC_RAM_PARITY_EN
  assign rd_err = 1'b0;
`endif

endmodule
